// File: rtl/m_axis_cq_adapt_if.sv
// rtl/m_axis_cq_adapt_if.sv - AXI-Stream bundle used on both sides of the CQ adapter
interface m_axis_cq_adapt_if #(
  parameter int DATA_WIDTH  = 128,
  parameter int KEEP_WIDTH  = 16,
  parameter int USER_WIDTH  = 9,
  parameter int READY_WIDTH = 1
);
  logic [DATA_WIDTH-1:0]  tdata;
  logic [KEEP_WIDTH-1:0]  tkeep;
  logic                   tlast;
  logic [USER_WIDTH-1:0]  tuser;
  logic                   tvalid;
  logic [READY_WIDTH-1:0] tready;

  modport master (output tdata, tkeep, tlast, tuser, tvalid, input tready);
  modport slave  (input tdata, tkeep, tlast, tuser, tvalid, output tready);
endinterface

// File: rtl/m_axis_cq_adapt.sv
// rtl/m_axis_cq_adapt.sv - UltraScale+ CQ request to legacy 3DW/4DW TLP adapter
// Optional output skid buffer enabled by defining M_AXIS_CQ_ADAPT_OUTREG_EN.
module m_axis_cq_adapt #(
  parameter int DATA_WIDTH = 128,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic              user_clk,
  input  logic              user_reset_n,
  m_axis_cq_adapt_if.slave  m_axis_cq,
  m_axis_cq_adapt_if.master m_axis_cq_a,
  output logic              cq_drop
);
  typedef enum logic [2:0] {IDLE, RD_OUT, WR4_HDR, WR4_DATA, WR3_DATA, FLUSH, DROP} state_t;

  state_t                  state;
  logic [127:0]            hdr;
  logic                    hdr_4dw;
  logic [95:0]             res;
  logic [2:0]              res_keep;
  logic                    res_disc;
  logic                    first;
  logic [6:0]              bar_hit;
  logic                    ready_en;

  logic [DATA_WIDTH-1:0]   d;
  logic [3:0]              d_type;
  logic                    d_supp, d_mem, d_wr, d_4dw, in_disc;
  logic [31:0]             d_dw0, d_dw1, d_dw2, d_dw3;
  logic [6:0]              d_bar_hit;

  logic [DATA_WIDTH-1:0]   o_tdata;
  logic [KEEP_WIDTH-1:0]   o_tkeep;
  logic                    o_tlast;
  logic [8:0]              o_tuser;
  logic                    o_tvalid;
  logic                    o_tready;
  logic                    out_hs;
  logic                    cq_rdy;
  logic                    unused_tuser;

  function automatic logic [15:0] expand_keep(input logic [3:0] k);
    return {{4{k[3]}}, {4{k[2]}}, {4{k[1]}}, {4{k[0]}}};
  endfunction

  assign d            = m_axis_cq.tdata;
  assign in_disc      = m_axis_cq.tuser[41];
  assign unused_tuser = &{1'b0, m_axis_cq.tuser[87:42], m_axis_cq.tuser[40:8]};
  assign out_hs       = o_tvalid && o_tready;
  assign m_axis_cq.tready = {4{cq_rdy}};

  // Descriptor decode into the legacy header DWs
  always_comb begin
    d_type    = d[78:75];
    d_supp    = (d_type[3:2] == 2'b00);
    d_mem     = ~d_type[1];
    d_wr      = d_type[0];
    d_4dw     = d_mem & (|d[63:32]);
    d_dw0     = {1'b0, d_wr, d_4dw, 3'b000, ~d_mem, 1'b0,
                 1'b0, d[123:121], 1'b0, d[126], 4'b0000, d[125:124], 2'b00, d[73:64]};
    d_dw1     = {d[95:80], d[103:96], m_axis_cq.tuser[7:4], m_axis_cq.tuser[3:0]};
    d_dw2     = d_4dw ? d[63:32] : {d[31:2], 2'b00};
    d_dw3     = d_4dw ? {d[31:2], 2'b00} : 32'h0;
    d_bar_hit = (d[114:112] == 3'd7) ? 7'h0 : (7'h1 << d[114:112]);
  end

  always_comb begin
    o_tvalid = 1'b0;
    o_tdata  = hdr;
    o_tkeep  = '0;
    o_tlast  = 1'b0;
    o_tuser  = {bar_hit, res_disc, 1'b0};
    cq_rdy   = 1'b0;
    case (state)
      IDLE, DROP: cq_rdy = ready_en;
      RD_OUT: begin
        o_tvalid = 1'b1;
        o_tkeep  = hdr_4dw ? 16'hFFFF : 16'h0FFF;
        o_tlast  = 1'b1;
        o_tuser  = {bar_hit, res_disc, 1'b1};
      end
      WR4_HDR: begin
        o_tvalid = 1'b1;
        o_tkeep  = 16'hFFFF;
        o_tuser  = {bar_hit, res_disc, 1'b1};
      end
      WR4_DATA: begin
        o_tvalid = m_axis_cq.tvalid;
        o_tdata  = d;
        o_tkeep  = expand_keep(m_axis_cq.tkeep);
        o_tlast  = m_axis_cq.tlast;
        o_tuser  = {bar_hit, in_disc, 1'b0};
        cq_rdy   = o_tready;
      end
      WR3_DATA: begin
        // Input DW0 completes the 4-DW output beat behind the residual
        o_tvalid = m_axis_cq.tvalid;
        o_tdata  = {d[31:0], res};
        o_tkeep  = {{4{m_axis_cq.tkeep[0]}}, 12'hFFF};
        o_tlast  = m_axis_cq.tlast && !(|m_axis_cq.tkeep[3:1]);
        o_tuser  = {bar_hit, in_disc | res_disc, first};
        cq_rdy   = o_tready;
      end
      FLUSH: begin
        o_tvalid = 1'b1;
        o_tdata  = {32'h0, res};
        o_tkeep  = {4'h0, {4{res_keep[2]}}, {4{res_keep[1]}}, {4{res_keep[0]}}};
        o_tlast  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      state    <= IDLE;
      hdr      <= '0;
      hdr_4dw  <= 1'b0;
      res      <= '0;
      res_keep <= '0;
      res_disc <= 1'b0;
      first    <= 1'b0;
      bar_hit  <= '0;
      ready_en <= 1'b0;
      cq_drop  <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      cq_drop  <= 1'b0;
      case (state)
        IDLE: if (ready_en && m_axis_cq.tvalid) begin
          hdr      <= {d_dw3, d_dw2, d_dw1, d_dw0};
          res      <= {d_dw2, d_dw1, d_dw0};
          hdr_4dw  <= d_4dw;
          res_disc <= in_disc;
          first    <= 1'b1;
          bar_hit  <= d_bar_hit;
          if (!d_supp) begin
            cq_drop <= 1'b1;
            state   <= m_axis_cq.tlast ? IDLE : DROP;
          end else if (!d_wr) begin
            state <= RD_OUT;
          end else if (d_4dw) begin
            state <= WR4_HDR;
          end else begin
            state <= WR3_DATA;
          end
        end
        RD_OUT:   if (out_hs) state <= IDLE;
        WR4_HDR:  if (out_hs) state <= WR4_DATA;
        WR4_DATA: if (out_hs && m_axis_cq.tlast) state <= IDLE;
        WR3_DATA: if (out_hs) begin
          res      <= d[127:32];
          res_keep <= m_axis_cq.tkeep[3:1];
          res_disc <= in_disc;
          first    <= 1'b0;
          if (m_axis_cq.tlast) state <= (|m_axis_cq.tkeep[3:1]) ? FLUSH : IDLE;
        end
        FLUSH:    if (out_hs) state <= IDLE;
        DROP:     if (m_axis_cq.tvalid && m_axis_cq.tlast) state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

`ifdef M_AXIS_CQ_ADAPT_OUTREG_EN
  localparam int PW = DATA_WIDTH + KEEP_WIDTH + 10;

  logic [PW-1:0] in_p, main_p, skid_p;
  logic          main_v, skid_v, rdy_r;

  assign in_p     = {o_tdata, o_tkeep, o_tlast, o_tuser};
  assign o_tready = rdy_r;
  assign {m_axis_cq_a.tdata, m_axis_cq_a.tkeep, m_axis_cq_a.tlast, m_axis_cq_a.tuser} = main_p;
  assign m_axis_cq_a.tvalid = main_v;

  // Two-entry skid: upstream ready is a flop, skid absorbs the beat in flight
  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      main_p <= '0;
      skid_p <= '0;
      main_v <= 1'b0;
      skid_v <= 1'b0;
      rdy_r  <= 1'b0;
    end else begin
      rdy_r <= m_axis_cq_a.tready || (!skid_v && (!main_v || !o_tvalid));
      if (rdy_r) begin
        if (m_axis_cq_a.tready || !main_v) begin
          main_p <= in_p;
          main_v <= o_tvalid;
        end else begin
          skid_p <= in_p;
          skid_v <= o_tvalid;
        end
      end else if (m_axis_cq_a.tready) begin
        main_p <= skid_p;
        main_v <= skid_v;
        skid_v <= 1'b0;
      end
    end
  end
`else
  assign o_tready           = m_axis_cq_a.tready;
  assign m_axis_cq_a.tdata  = o_tdata;
  assign m_axis_cq_a.tkeep  = o_tkeep;
  assign m_axis_cq_a.tlast  = o_tlast;
  assign m_axis_cq_a.tuser  = o_tuser;
  assign m_axis_cq_a.tvalid = o_tvalid;
`endif
endmodule

// File: doc/m_axis_cq_adapt.md
# m_axis_cq_adapt

Receive-side companion to the completer-completion adapter in the UltraScale+ PHY wrapper. Converts 128-bit CQ requests (4-DW descriptor beat, DWORD-aligned payload) from the hard block into legacy PCIe TLP format (3DW/4DW header, payload packed behind header) for the LitePCIe depacketizer. Sits between core `m_axis_cq_*` and the user-side `m_axis_cq_*_a` stream. Repacks payload for 3DW headers, drops unsupported request types and maps BAR id to one-hot BAR hit.

## Interface

- DATA_WIDTH, 128, stream width; only 128 supported
- KEEP_WIDTH, DATA_WIDTH/8, output byte-keep width
- user_clk  in  1  clock
- user_reset_n  in  1  asynchronous active-low reset
- m_axis_cq_tdata  in  128  core CQ data
- m_axis_cq_tkeep  in  4  per-DW keep
- m_axis_cq_tlast  in  1  end of packet
- m_axis_cq_tuser  in  88  first_be[3:0], last_be[7:4], sop[40], discontinue[41]; rest ignored
- m_axis_cq_tvalid  in  1  valid
- m_axis_cq_tready  out  4  ready, replicated on all bits
- m_axis_cq_tdata_a  out  128  legacy TLP data
- m_axis_cq_tkeep_a  out  16  byte keep
- m_axis_cq_tlast_a  out  1  end of TLP
- m_axis_cq_tuser_a  out  9  [0] first beat, [1] discontinue, [8:2] BAR hit one-hot
- m_axis_cq_tvalid_a  out  1  valid
- m_axis_cq_tready_a  in  1  user ready
- cq_drop  out  1  one-cycle pulse per dropped request

## Operation

- Descriptor: addr[63:2]=d[63:2], dwcnt=d[74:64], reqtype=d[78:75], reqid=d[95:80], tag=d[103:96], bar_id=d[114:112], tc=d[123:121], attr=d[126:124].
- Supported: MRd(0000), MWr(0001), IORd(0010), IOWr(0011). Others: DROP, cq_drop pulses on descriptor accept.
- 4DW when addr[63:32]!=0 and memory type; else 3DW. IO always 3DW.
- Header DW0: fmt (MRd 000/001, MWr 010/011, IORd 000, IOWr 010), type 00000 mem / 00010 IO, tc[22:20], attr[2] at bit 18, attr[1:0] at [13:12], TD=EP=0, length=dwcnt[9:0] (1024 -> 0). DW1: {reqid, tag, last_be, first_be}. DW2/3: {addr[31:2],00} (3DW) or addr[63:32], {addr[31:2],00} (4DW). Header DW n occupies tdata[32n+31:32n].
- bar_hit = 1<<bar_id latched at descriptor; bar_id>6 -> 0.
- FSM states: IDLE, RD_OUT, WR4_HDR, WR4_DATA, WR3_DATA, FLUSH, DROP.
- IDLE: tready=F; accept descriptor, load header regs and 3-DW residual (header DW0-2); go RD_OUT (reads), WR4_HDR, WR3_DATA, or DROP (DROP skipped to IDLE if descriptor tlast=1).
- RD_OUT: tready=0; emit header, tkeep FFF (3DW) or FFFF (4DW), tlast=1; IDLE on out handshake.
- WR4_HDR: emit header, tkeep FFFF, tlast=0; then WR4_DATA: pass-through, tready=tready_a, tkeep_a each DW bit expanded x4.
- WR3_DATA: tvalid_a=tvalid, tready=tready_a; tdata_a={in DW0, residual}, tkeep_a={4{keep[0]}},FFF; residual<=in DW3..1. On last beat with k=popcount(keep): k=1 -> tlast_a, IDLE; k>1 -> FLUSH.
- FLUSH: tready=0; emit residual, keep for k-1 DWs, tlast_a=1; IDLE.
- DROP: tready=F, discard until tlast beat.
- tuser_a[0] on first output beat; tuser_a[1]=discontinue OR of input beats contributing to the output beat.

## Timing

- Reset values: tvalid_a=0, tready=0, cq_drop=0, state IDLE, residual/header 0; tready=F first cycle after deassertion.
- Read: output valid 1 cycle after descriptor accept. Write: header/first beat 1 cycle after descriptor; data zero added latency (combinational path) except FLUSH +1 beat.
- tvalid_a, when high, holds data stable until tready_a; no input accepted while tvalid_a && !tready_a in registered states.
- Reset mid-packet: all state cleared immediately, partial TLP abandoned, no tlast_a emitted.

## Configuration

- M_AXIS_CQ_ADAPT_OUTREG_EN: defined -> full-throughput two-entry skid buffer on the `_a` output; +1 cycle latency, tready toward core is registered. Undefined -> outputs direct from FSM/datapath as above.

## Test plan

- MRd 32-bit addr 0x1000_0040, dwcnt 1, tag 0x12, bar 0 -> one beat, DW0=0x0000_0001, DW2=0x1000_0040, tkeep 0FFF, tlast, tuser_a[8:2]=0000001.
- MRd addr 0x1_0000_0000 -> fmt 001, DW2=0x0000_0001, DW3=0, tkeep FFFF.
- MWr 3DW dwcnt 4, data D0-D3 one beat -> beat1={D0,hdr} tkeep FFFF; beat2 D1-D3, tkeep 0FFF, tlast.
- MWr 3DW dwcnt 1 -> single beat {D0,hdr}, tlast, no FLUSH; MWr 4DW dwcnt 8 -> hdr + 2 pass-through beats.
- Message type 1100 with 2 payload beats -> all beats consumed, no output, cq_drop one pulse.
- tready_a low 5 cycles mid-MWr, then reset asserted -> data stable while stalled; after reset tvalid_a=0, next MRd correct.
